// File: rtl/tft_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tft_cmd_sequencer
// Purpose  : Drives the panel hardware reset, issues the init command list,
//            then per frame programs the full-screen window and streams
//            RGB565 pixels (high byte first) through the byte-level SPI
//            engine, one byte outstanding at a time.
// Options  : TFT_SEQ_MADCTL_EN - adds MADCTL (0x36, MADCTL_VAL) to init list.
// Revision : 1.0 - initial release
// ============================================================================
module tft_cmd_sequencer #(
  parameter int         WIDTH        = 240,
  parameter int         HEIGHT       = 320,
  parameter int         RST_LOW_CYC  = 16,
  parameter int         RST_WAIT_CYC = 64,   // must be >= 2
  parameter int         SLP_WAIT_CYC = 64,
  parameter logic [7:0] MADCTL_VAL   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  input  logic        spi_done,
  output logic        lcd_rst_n,
  output logic        init_done,
  input  logic        frame_req,
  output logic        busy,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_done
);

  localparam int NPIX    = WIDTH * HEIGHT;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int MAX_A   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int MAX_DLY = (MAX_A > SLP_WAIT_CYC) ? MAX_A : SLP_WAIT_CYC;
  localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  localparam logic [DLY_W-1:0] RST_LOW_LAST  = DLY_W'(RST_LOW_CYC - 1);
  localparam logic [DLY_W-1:0] RST_WAIT_LAST = DLY_W'(RST_WAIT_CYC - 1);
  localparam logic [DLY_W-1:0] SLP_LAST      = DLY_W'(SLP_WAIT_CYC - 1);
  localparam logic [PIX_W-1:0] PIX_LAST      = PIX_W'(NPIX - 1);

`ifdef TFT_SEQ_MADCTL_EN
  localparam int INIT_LEN = 7;
`else
  localparam int INIT_LEN = 5;
`endif
  localparam logic [3:0]  INIT_LAST   = 4'(INIT_LEN - 1);
  localparam logic [3:0]  HDR_LAST    = 4'd10;
  localparam logic [3:0]  IDX_SWRESET = 4'd0;
  localparam logic [3:0]  IDX_SLPOUT  = 4'd1;
  localparam logic [15:0] W_LAST      = 16'(WIDTH - 1);
  localparam logic [15:0] H_LAST      = 16'(HEIGHT - 1);

  typedef enum logic [3:0] {
    S_RST_LOW, S_RST_WAIT, S_INIT_SEND, S_INIT_WAIT, S_INIT_DLY, S_READY,
    S_HDR_SEND, S_HDR_WAIT, S_PIX_ACCEPT, S_PIX_HI_WAIT, S_PIX_LO_SEND,
    S_PIX_LO_WAIT
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] dly;
  logic [3:0]       idx;
  logic [PIX_W-1:0] pix_cnt;
  logic             last_pix;
  logic [7:0]       lo_byte;
  logic [7:0]       init_byte;
  logic             init_dc;
  logic [7:0]       hdr_byte;
  logic             hdr_dc;

`ifndef TFT_SEQ_MADCTL_EN
  // MADCTL_VAL has no effect in this build; fold it into a deliberately unused net.
  logic unused_madctl;
  assign unused_madctl = ^MADCTL_VAL;
`endif

  // Init command list ROM: byte and dc flag for the current list index.
  always_comb begin
    init_byte = 8'h00;
    init_dc   = 1'b0;
    case (idx)
      4'd0: init_byte = 8'h01;                       // SWRESET
      4'd1: init_byte = 8'h11;                       // SLPOUT
      4'd2: init_byte = 8'h3A;                       // COLMOD
      4'd3: begin init_byte = 8'h55; init_dc = 1'b1; end
`ifdef TFT_SEQ_MADCTL_EN
      4'd4: init_byte = 8'h36;                       // MADCTL
      4'd5: begin init_byte = MADCTL_VAL; init_dc = 1'b1; end
      4'd6: init_byte = 8'h29;                       // DISPON
`else
      4'd4: init_byte = 8'h29;                       // DISPON
`endif
      default: ;
    endcase
  end

  // Frame header ROM: full-screen CASET/RASET window followed by RAMWR.
  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (idx)
      4'd0:    begin hdr_byte = 8'h2A; hdr_dc = 1'b0; end
      4'd3:    hdr_byte = W_LAST[15:8];
      4'd4:    hdr_byte = W_LAST[7:0];
      4'd5:    begin hdr_byte = 8'h2B; hdr_dc = 1'b0; end
      4'd8:    hdr_byte = H_LAST[15:8];
      4'd9:    hdr_byte = H_LAST[7:0];
      4'd10:   begin hdr_byte = 8'h2C; hdr_dc = 1'b0; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered engine/panel outputs; one byte in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RST_LOW;
      dly        <= '0;
      idx        <= '0;
      pix_cnt    <= '0;
      last_pix   <= 1'b0;
      lo_byte    <= 8'h00;
      spi_start  <= 1'b0;
      spi_data   <= 8'h00;
      spi_dc     <= 1'b0;
      lcd_rst_n  <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b1;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_RST_LOW: begin
          if (dly == RST_LOW_LAST) begin
            lcd_rst_n <= 1'b1;
            // Start at 1: the INIT_SEND cycle completes the post-reset wait.
            dly       <= DLY_W'(1);
            state     <= S_RST_WAIT;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (dly == RST_WAIT_LAST) begin
            dly   <= '0;
            idx   <= '0;
            state <= S_INIT_SEND;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        S_INIT_SEND: begin
          spi_start <= 1'b1;
          spi_data  <= init_byte;
          spi_dc    <= init_dc;
          state     <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (spi_done) begin
            if (idx == INIT_LAST) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_READY;
            end else begin
              idx <= idx + 1'b1;
              if (idx == IDX_SWRESET || idx == IDX_SLPOUT) begin
                dly   <= '0;
                state <= S_INIT_DLY;
              end else begin
                state <= S_INIT_SEND;
              end
            end
          end
        end
        S_INIT_DLY: begin
          if (dly == SLP_LAST) begin
            dly   <= '0;
            state <= S_INIT_SEND;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        S_READY: begin
          pix_cnt  <= '0;
          last_pix <= 1'b0;
          if (frame_req) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_HDR_SEND;
          end
        end
        S_HDR_SEND: begin
          spi_start <= 1'b1;
          spi_data  <= hdr_byte;
          spi_dc    <= hdr_dc;
          state     <= S_HDR_WAIT;
        end
        S_HDR_WAIT: begin
          if (spi_done) begin
            if (idx == HDR_LAST) begin
              pix_ready <= 1'b1;
              state     <= S_PIX_ACCEPT;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_HDR_SEND;
            end
          end
        end
        S_PIX_ACCEPT: begin
          if (pix_valid) begin
            spi_start <= 1'b1;
            spi_data  <= pix_data[15:8];
            spi_dc    <= 1'b1;
            lo_byte   <= pix_data[7:0];
            pix_ready <= 1'b0;
            last_pix  <= (pix_cnt == PIX_LAST);
            if (pix_cnt != PIX_LAST) pix_cnt <= pix_cnt + 1'b1;
            state     <= S_PIX_HI_WAIT;
          end
        end
        S_PIX_HI_WAIT: begin
          if (spi_done) state <= S_PIX_LO_SEND;
        end
        S_PIX_LO_SEND: begin
          spi_start <= 1'b1;
          spi_data  <= lo_byte;
          spi_dc    <= 1'b1;
          state     <= S_PIX_LO_WAIT;
        end
        S_PIX_LO_WAIT: begin
          if (spi_done) begin
            if (last_pix) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_READY;
            end else begin
              pix_ready <= 1'b1;
              state     <= S_PIX_ACCEPT;
            end
          end
        end
        default: state <= S_RST_LOW;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tft_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_cmd_sequencer
// Purpose  : Scoreboard bench for tft_cmd_sequencer. Stimulus pushes the
//            expected {dc,byte} stream; a combined engine-model/monitor pops
//            and compares on every spi_start and checks handshake timing.
// Options  : TFT_SEQ_MADCTL_EN - expects MADCTL in the init list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_cmd_sequencer;

  localparam int         W      = 4;
  localparam int         H      = 2;
  localparam int         NPIX   = W * H;
  localparam int         RLOW   = 16;
  localparam int         RWAIT  = 64;
  localparam int         SLP    = 64;
  localparam logic [7:0] MADCTL = 8'h48;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_done;
  logic        lcd_rst_n;
  logic        init_done;
  logic        frame_req;
  logic        busy;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;

  tft_cmd_sequencer #(
    .WIDTH(W), .HEIGHT(H), .RST_LOW_CYC(RLOW), .RST_WAIT_CYC(RWAIT),
    .SLP_WAIT_CYC(SLP), .MADCTL_VAL(MADCTL)
  ) dut (
    .clk(clk), .rst(rst), .spi_start(spi_start), .spi_data(spi_data),
    .spi_dc(spi_dc), .spi_done(spi_done), .lcd_rst_n(lcd_rst_n),
    .init_done(init_done), .frame_req(frame_req), .busy(busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  logic [8:0] exp_q[$];
  int         frames_req  = 0;
  int         frames_done = 0;
  int         rel_cyc     = 0;
  bit         spur        = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model: expected byte stream ----------------
  task automatic push_byte(input bit dc, input logic [7:0] b);
    exp_q.push_back({dc, b});
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h11);
    push_byte(1'b0, 8'h3A);
    push_byte(1'b1, 8'h55);
`ifdef TFT_SEQ_MADCTL_EN
    push_byte(1'b0, 8'h36);
    push_byte(1'b1, MADCTL);
`endif
    push_byte(1'b0, 8'h29);
  endtask

  task automatic push_window(input logic [7:0] cmd, input int extent);
    push_byte(1'b0, cmd);
    push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'h00);
    push_byte(1'b1, 8'((extent - 1) / 256));
    push_byte(1'b1, 8'((extent - 1) % 256));
  endtask

  // Cycles from the previous byte's spi_done to this init byte's spi_start:
  // a 1-cycle gap normally, plus the settle delay after SWRESET and SLPOUT.
  function automatic int exp_gap(input int i);
    return (i == 1 || i == 2) ? SLP + 2 : 2;
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name, 32'({spi_start, spi_data, spi_dc, lcd_rst_n, init_done,
                     busy, pix_ready, frame_done}),
          32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
  endtask

  // ---------------- engine model + scoreboard monitor ----------------
  initial begin
    logic [8:0] e;
    bit eng_busy, prev_lcd, prev_init, first_pending;
    int eng_cnt, done_cyc, rise_cyc, init_idx, nbytes;
    eng_busy = 0; prev_lcd = 0; prev_init = 0; first_pending = 0;
    eng_cnt = 0; done_cyc = 0; rise_cyc = 0; init_idx = 0; nbytes = 0;
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        spi_done = 1'b0; eng_busy = 0; prev_lcd = 0; prev_init = 0;
        first_pending = 0; init_idx = 0;
      end else begin
        spi_done = spur;
        if (eng_busy) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            spi_done = 1'b1; eng_busy = 0; done_cyc = cyc;
          end
        end
        if (lcd_rst_n && !prev_lcd) begin
          check("lcd_rst_n_low_cycles", cyc - rel_cyc, RLOW);
          rise_cyc = cyc; first_pending = 1;
        end
        prev_lcd = lcd_rst_n;
        if (spi_start) begin
          if (first_pending) begin
            check("first_start_after_rst_release", cyc - rise_cyc, RWAIT);
            first_pending = 0;
          end else if (!init_done) begin
            check($sformatf("init_gap_%0d", init_idx), cyc - done_cyc, exp_gap(init_idx));
          end
          if (!init_done) init_idx++;
          check("one_byte_outstanding", 32'(eng_busy), 0);
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_byte: got dc=%0d data=%02h, expected no byte", spi_dc, spi_data);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte_%0d", nbytes), 32'({spi_dc, spi_data}), 32'(e));
          end
          nbytes++;
          eng_busy = 1;
          eng_cnt  = init_done ? int'($urandom_range(1, 12)) : 20;
        end
        if (init_done && !prev_init) begin
          check("init_done_timing", cyc - done_cyc, 1);
          check("init_list_consumed", exp_q.size(), 0);
        end
        prev_init = init_done;
        if (frame_done) begin
          frames_done++;
          check("frame_done_timing", cyc - done_cyc, 1);
          check("frame_bytes_consumed", exp_q.size(), 0);
          check("busy_low_at_frame_done", 32'(busy), 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 3000) begin @(negedge clk); t++; end
    check("init_done_reached", 32'(init_done), 1);
  endtask

  task automatic idle_spurious();
    for (int i = 0; i < 3; i++) begin
      spur = 1'b1; @(negedge clk); spur = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("ready_ignores_stray_done", 32'({busy, pix_ready, spi_start}), 0);
  endtask

  task automatic run_frame(input bit stall, input int abort_at);
    logic [15:0] px[NPIX];
    int k, t, fd0, stall_bad;
    bit stalled;
    for (int i = 0; i < NPIX; i++) px[i] = 16'($urandom);
    px[0] = 16'hA55A;
    push_window(8'h2A, W);
    push_window(8'h2B, H);
    push_byte(1'b0, 8'h2C);
    for (int i = 0; i < NPIX; i++) begin
      push_byte(1'b1, px[i][15:8]);
      push_byte(1'b1, px[i][7:0]);
    end
    fd0 = frames_done;
    frame_req = 1'b1; @(negedge clk); frame_req = 1'b0;
    k = 0; t = 0; stalled = 0;
    while (k < NPIX && k != abort_at && t < 5000) begin
      @(negedge clk); t++;
      frame_req = (k == 2);
      if (stall && !stalled && k == NPIX / 2 && pix_ready) begin
        stalled = 1; stall_bad = 0; pix_valid = 1'b0;
        for (int s = 0; s < 50; s++) begin
          pix_data = 16'($urandom);
          @(negedge clk);
          if (!pix_ready || spi_start) stall_bad++;
        end
        check("stall_no_activity", stall_bad, 0);
      end
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data  = pix_valid ? px[k] : 16'($urandom);
      if (pix_valid && pix_ready) k++;
    end
    frame_req = 1'b0;
    if (abort_at >= 0) return;
    check("pixels_accepted", k, NPIX);
    @(negedge clk); pix_valid = 1'b0;
    frames_req++;
    t = 0;
    while (frames_done == fd0 && t < 5000) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    check("frame_done_once", frames_done - fd0, 1);
    check("idle_after_frame", 32'({busy, pix_ready}), 0);
  endtask

  initial begin
    rst = 1'b1; frame_req = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    push_init();
    rel_cyc = cyc; rst = 1'b0;
    // frame requests during reset-wait and during init are ignored
    repeat (30) @(negedge clk);
    frame_req = 1'b1; repeat (3) @(negedge clk); frame_req = 1'b0;
    repeat (150) @(negedge clk);
    frame_req = 1'b1; repeat (3) @(negedge clk); frame_req = 1'b0;
    wait_init();
    idle_spurious();
    run_frame(1'b0, -1);
    run_frame(1'b1, -1);
    run_frame(1'b0, -1);
    // reset in the middle of pixel streaming
    run_frame(1'b0, 3);
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    check_reset_outputs("async_reset_outputs");
    exp_q.delete(); pix_valid = 1'b0; frame_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset_outputs");
    push_init();
    rel_cyc = cyc; rst = 1'b0;
    wait_init();
    run_frame(1'b0, -1);
    repeat (20) @(negedge clk);
    check("frame_count", frames_done, frames_req);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
